// File: rtl/ship_drawer_if.sv
// Pixel-write bus between the ship drawer and the VGA adapter.
// The movement position and the sequence status also travel on this bus.
interface ship_drawer_if;
  logic [7:0] x_val;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;

  // The drawer side accepts a position and drives pixel writes.
  modport master (
    input  x_val,
    output vga_x, vga_y, vga_colour, plot, busy, done
  );

  // The adapter/movement side drives a position and accepts pixel writes.
  modport slave (
    output x_val,
    input  vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/ship_drawer.sv
// Ship sprite renderer: on each position change it erases the old footprint,
// draws the new one, and plots one pixel per clock into the VGA adapter.
module ship_drawer #(
  parameter int unsigned SHIP_W      = 8,
  parameter int unsigned SHIP_H      = 4,
  parameter int unsigned Y_POS       = 110,
  parameter logic [2:0]  SHIP_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic          clock,
  input  logic          reset,
  ship_drawer_if.master bus
);

  localparam int unsigned CX_W    = $clog2(SHIP_W + 1);
  localparam int unsigned CY_W    = $clog2(SHIP_H + 1);
  localparam logic [7:0]  MAX_X   = 8'(160 - SHIP_W);
  localparam logic [6:0]  Y_TOP   = 7'(Y_POS);
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(SHIP_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(SHIP_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [7:0]      drawn_x_q;
  logic [7:0]      new_x_q;
  logic            pending_q;
  logic [CX_W-1:0] cx_q;
  logic [CY_W-1:0] cy_q;
  logic [7:0]      vga_x_q;
  logic [6:0]      vga_y_q;
  logic [2:0]      colour_q;
  logic            plot_q;
  logic            busy_q;
  logic            done_q;

  logic [7:0]      tgt;
  logic            row_end;
  logic            last_px;
  logic [CX_W-1:0] cx_d;
  logic [CY_W-1:0] cy_d;

  // Clamped target and the scan position that follows the one being plotted.
  always_comb begin
    tgt     = (bus.x_val > MAX_X) ? MAX_X : bus.x_val;
    row_end = (cx_q == CX_LAST);
    last_px = row_end && (cy_q == CY_LAST);
    cx_d    = row_end ? '0 : cx_q + CX_W'(1);
    cy_d    = row_end ? cy_q + CY_W'(1) : cy_q;
  end

  // cx_q/cy_q always name the pixel currently presented on the output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      drawn_x_q <= '0;
      new_x_q   <= '0;
      pending_q <= 1'b1;
      cx_q      <= '0;
      cy_q      <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          plot_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if ((tgt != drawn_x_q) || pending_q) begin
            state_q   <= S_ERASE;
            new_x_q   <= tgt;
            pending_q <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            vga_x_q   <= drawn_x_q;
            vga_y_q   <= Y_TOP;
            colour_q  <= BG_COLOUR;
            plot_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_ERASE: begin
          if (last_px) begin
            state_q  <= S_DRAW;
            cx_q     <= '0;
            cy_q     <= '0;
            vga_x_q  <= new_x_q;
            vga_y_q  <= Y_TOP;
            colour_q <= SHIP_COLOUR;
          end else begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            vga_x_q <= drawn_x_q + 8'(cx_d);
            vga_y_q <= Y_TOP + 7'(cy_d);
          end
        end
        S_DRAW: begin
          if (last_px) begin
            state_q <= S_DONE;
            cx_q    <= '0;
            cy_q    <= '0;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            vga_x_q <= new_x_q + 8'(cx_d);
            vga_y_q <= Y_TOP + 7'(cy_d);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          drawn_x_q <= new_x_q;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_ship_drawer.sv
// Directed bench for ship_drawer: table of redraw transactions checked pixel by
// pixel, plus hand sequences for clamp-equal idle, mid-sequence reset and long idle.
module tb_ship_drawer;

  logic clock;
  logic reset;

  ship_drawer_if bus ();

  ship_drawer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       plot;
    logic       busy;
    logic       done;
    logic [2:0] colour;
    logic [7:0] x;
    logic [6:0] y;
  } obs_t;

  typedef struct {
    logic [7:0] x_in;
    bit         has_mid;
    logic [7:0] mid_a;
    logic [7:0] mid_b;
    logic [7:0] exp_erase;
    logic [7:0] exp_draw;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic obs_t sample();
    obs_t o;
    o.plot   = bus.plot;
    o.busy   = bus.busy;
    o.done   = bus.done;
    o.colour = bus.vga_colour;
    o.x      = bus.vga_x;
    o.y      = bus.vga_y;
    return o;
  endfunction

  // Expected outputs for cycle c (1-based) of an 8x4 erase+draw at y=110.
  function automatic obs_t exp_at(int c, logic [7:0] eb, logic [7:0] db);
    obs_t e;
    int   p;
    e = '0;
    p = 0;
    if (c >= 1 && c <= 64) begin
      p        = (c <= 32) ? c - 1 : c - 33;
      e.plot   = 1'b1;
      e.busy   = 1'b1;
      e.colour = (c <= 32) ? 3'b000 : 3'b111;
      e.x      = ((c <= 32) ? eb : db) + 8'(p % 8);
      e.y      = 7'(110 + p / 8);
    end else if (c == 65) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic check_obs(string name, int c, obs_t act, obs_t exp);
    bit ok;
    n_vec++;
    if (exp.plot) ok = (act == exp);
    else          ok = ({act.plot, act.busy, act.done} == {exp.plot, exp.busy, exp.done});
    if (!ok) begin
      n_err++;
      $display("FAIL %s cycle %0d: got plot=%0b busy=%0b done=%0b col=%0d x=%0d y=%0d, want plot=%0b busy=%0b done=%0b col=%0d x=%0d y=%0d",
               name, c, act.plot, act.busy, act.done, act.colour, act.x, act.y,
               exp.plot, exp.busy, exp.done, exp.colour, exp.x, exp.y);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Runs one full sequence starting at the next edge, plus the following idle cycle.
  task automatic run_seq(string name, logic [7:0] eb, logic [7:0] db,
                         bit has_mid, logic [7:0] mid_a, logic [7:0] mid_b);
    obs_t act;
    int   over = 0;
    for (int c = 1; c <= 66; c++) begin
      @(posedge clock);
      #1;
      act = sample();
      check_obs(name, c, act, exp_at(c, eb, db));
      if (act.plot && act.x > 8'd159) over++;
      if (has_mid && c == 10) bus.x_val = mid_a;
      if (has_mid && c == 40) bus.x_val = mid_b;
    end
    check_int({name, "_x_range"}, over, 0);
  endtask

  task automatic idle_hold(string name, int cycles);
    int active = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (bus.plot || bus.busy || bus.done) active++;
    end
    check_int(name, active, 0);
  endtask

  vec_t vecs[6];

  initial begin
    obs_t act;

    vecs[0] = '{x_in: 8'd0,   has_mid: 1'b0, mid_a: 8'd0, mid_b: 8'd0, exp_erase: 8'd0,   exp_draw: 8'd0};
    vecs[1] = '{x_in: 8'd5,   has_mid: 1'b1, mid_a: 8'd6, mid_b: 8'd9, exp_erase: 8'd0,   exp_draw: 8'd5};
    vecs[2] = '{x_in: 8'd9,   has_mid: 1'b0, mid_a: 8'd0, mid_b: 8'd0, exp_erase: 8'd5,   exp_draw: 8'd9};
    vecs[3] = '{x_in: 8'd200, has_mid: 1'b0, mid_a: 8'd0, mid_b: 8'd0, exp_erase: 8'd9,   exp_draw: 8'd152};
    vecs[4] = '{x_in: 8'd3,   has_mid: 1'b0, mid_a: 8'd0, mid_b: 8'd0, exp_erase: 8'd152, exp_draw: 8'd3};
    vecs[5] = '{x_in: 8'd152, has_mid: 1'b0, mid_a: 8'd0, mid_b: 8'd0, exp_erase: 8'd3,   exp_draw: 8'd152};

    reset     = 1'b1;
    bus.x_val = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    act = sample();
    check_obs("reset_state", 0, act, '0);
    check_int("reset_xyc", int'({act.colour, act.x, act.y}), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      bus.x_val = vecs[i].x_in;
      run_seq($sformatf("vec%0d", i), vecs[i].exp_erase, vecs[i].exp_draw,
              vecs[i].has_mid, vecs[i].mid_a, vecs[i].mid_b);
      if (i == 3) begin
        // 255 clamps to the already-drawn 152: nothing may start.
        bus.x_val = 8'd255;
        idle_hold("clamp_equal_idle", 50);
        bus.x_val = 8'd200;
        idle_hold("clamp_equal_idle2", 10);
      end
    end

    // Reset during erase cycle 20 of a 152 -> 40 move.
    bus.x_val = 8'd40;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock);
      #1;
    end
    check_int("pre_reset_plot", int'(bus.plot), 1);
    reset = 1'b1;
    #1;
    act = sample();
    check_obs("reset_async", 0, act, '0);
    check_int("reset_async_xyc", int'({act.colour, act.x, act.y}), 0);
    @(posedge clock);
    #1;
    check_obs("reset_held", 0, sample(), '0);
    reset = 1'b0;
    run_seq("after_reset", 8'd0, 8'd40, 1'b0, 8'd0, 8'd0);

    idle_hold("idle_1000", 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
